phase_sampler: RTL and testbench

Downstream stage of the coupled-oscillator array. It owns the oscillator run/reset line (`ising_rstn`) and starts the oscillators on request. It then synchronises the N oscillator phase outputs into `clk` and counts, per spin, the cycles in which each oscillator disagrees with the reference oscillator 0. At the end it resolves a spin vector for the AXI read side.

---
 rtl/phase_sampler_pkg.sv | 18 +
 rtl/defines.vh | 10 +
 rtl/sync2.sv | 31 +++
 rtl/phase_sampler.sv | 142 ++++++++++++++
 tb/tb_phase_sampler.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_sampler_pkg.sv
// rtl/phase_sampler_pkg.sv - shared types for the phase sampler
// Purpose: FSM state type built on the encodings in defines.vh so that the
//          status register and the sampler agree on state values.
// Ports:   none (package).
`include "defines.vh"

package phase_sampler_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = `PS_IDLE,
    ST_SETTLE  = `PS_SETTLE,
    ST_MEASURE = `PS_MEASURE,
    ST_DONE    = `PS_DONE
  } state_t;

endpackage

// File: rtl/defines.vh
// rtl/defines.vh - phase_sampler FSM state encodings, shared with the AXI status register
`ifndef PHASE_SAMPLER_DEFINES_VH
`define PHASE_SAMPLER_DEFINES_VH

`define PS_IDLE    2'd0
`define PS_SETTLE  2'd1
`define PS_MEASURE 2'd2
`define PS_DONE    2'd3

`endif

// File: rtl/sync2.sv
// rtl/sync2.sv - parameterised-width two-flop synchroniser
// Purpose: brings W asynchronous bits into the clk domain.
// Ports:   clk  - destination clock
//          rst  - synchronous active-high reset, clears both stages
//          d    - asynchronous input bits
//          q    - synchronised output bits (2-cycle latency)
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] meta;
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= '0;
      stable <= '0;
    end else begin
      meta   <= d;
      stable <= meta;
    end
  end

  assign q = stable;

endmodule

// File: rtl/phase_sampler.sv
// rtl/phase_sampler.sv - oscillator run control and per-spin phase mismatch counter
// Purpose: starts the coupled-oscillator array, counts for each oscillator the
//          cycles it disagrees with reference oscillator 0, and resolves spins.
// Macro:   PHASE_SAMPLER_SETTLE_EN adds an annealing (SETTLE) phase of
//          settle_cycles+1 cycles before measurement.
// Ports:   clk           - system/AXI clock
//          axi_rst       - synchronous active-high reset
//          osc_in        - asynchronous oscillator phases
//          start         - one-cycle measurement request (IDLE only)
//          sample_cycles - window length in cycles, 0 treated as 1
//          settle_cycles - annealing time (macro builds only)
//          rd_sel        - count readback index
//          ising_rstn    - oscillator enable, 0 holds the array in reset
//          busy          - measurement in progress
//          done          - one-cycle pulse, spins valid
//          spins         - resolved spins, bit 0 always 0
//          rd_count      - mismatch count of oscillator rd_sel, 0 if out of range
module phase_sampler
  import phase_sampler_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int CNT_W = 16,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             axi_rst,
  input  logic [N-1:0]     osc_in,
  input  logic             start,
  input  logic [CNT_W-1:0] sample_cycles,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic [SEL_W-1:0] rd_sel,
  output logic             ising_rstn,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     spins,
  output logic [CNT_W-1:0] rd_count
);

  state_t           state;
  logic [N-1:0]     s;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_len;
  logic [CNT_W-1:0] win_load;
  logic [CNT_W-1:0] cnt     [N];
  logic [CNT_W-1:0] cnt_nxt [N];
  logic [N-1:0]     spin_nxt;

`ifdef PHASE_SAMPLER_SETTLE_EN
  logic [CNT_W-1:0] settle_cnt;
`else
  logic unused_settle;
  assign unused_settle = ^settle_cycles;
`endif

  sync2 #(.W(N)) u_sync (
    .clk (clk),
    .rst (axi_rst),
    .d   (osc_in),
    .q   (s)
  );

  assign win_load = (sample_cycles == '0) ? CNT_W'(1) : sample_cycles;

  // Counts including the current sample, so the last sample taken on the
  // transition into DONE is already part of the spin decision.
  always_comb begin
    spin_nxt = '0;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = cnt[i];
    end
    for (int i = 1; i < N; i++) begin
      cnt_nxt[i] = cnt[i] + CNT_W'(s[i] ^ s[0]);
      // 2*cnt > window at CNT_W+1 bits; an exact half resolves to 0
      spin_nxt[i] = {cnt_nxt[i], 1'b0} > {1'b0, win_len};
    end
  end

  // Out-of-range selects fall through to the zero default.
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_sel == SEL_W'(i)) rd_count = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state      <= ST_IDLE;
      win_cnt    <= '0;
      win_len    <= '0;
      spins      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ising_rstn <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
`ifdef PHASE_SAMPLER_SETTLE_EN
      settle_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            win_cnt    <= win_load;
            win_len    <= win_load;
            spins      <= '0;
            busy       <= 1'b1;
            ising_rstn <= 1'b1;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
`ifdef PHASE_SAMPLER_SETTLE_EN
            settle_cnt <= settle_cycles;
            state      <= ST_SETTLE;
`else
            state      <= ST_MEASURE;
`endif
          end
        end
`ifdef PHASE_SAMPLER_SETTLE_EN
        ST_SETTLE: begin
          if (settle_cnt == '0) state <= ST_MEASURE;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
`endif
        ST_MEASURE: begin
          for (int i = 1; i < N; i++) cnt[i] <= cnt_nxt[i];
          if (win_cnt == CNT_W'(1)) begin
            state      <= ST_DONE;
            spins      <= spin_nxt;
            done       <= 1'b1;
            busy       <= 1'b0;
            ising_rstn <= 1'b0;
          end else begin
            win_cnt <= win_cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sampler.sv
// tb/tb_phase_sampler.sv - directed self-checking bench for phase_sampler
module tb_phase_sampler;

  localparam int N     = 6;
  localparam int CNT_W = 16;
  localparam int SEL_W = 3;
`ifdef PHASE_SAMPLER_SETTLE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic             clk = 1'b0;
  logic             axi_rst;
  logic [N-1:0]     osc_in;
  logic             start;
  logic [CNT_W-1:0] sample_cycles;
  logic [CNT_W-1:0] settle_cycles;
  logic [SEL_W-1:0] rd_sel;
  logic             ising_rstn;
  logic             busy;
  logic             done;
  logic [N-1:0]     spins;
  logic [CNT_W-1:0] rd_count;

  int           n_checks = 0;
  int           n_errors = 0;
  int           mode     = 0;
  logic [N-1:0] osc_const = '0;
  int           t        = 0;
  logic         prev0    = 1'b0;

  always #5 clk = ~clk;

  phase_sampler #(.N(N), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .axi_rst       (axi_rst),
    .osc_in        (osc_in),
    .start         (start),
    .sample_cycles (sample_cycles),
    .settle_cycles (settle_cycles),
    .rd_sel        (rd_sel),
    .ising_rstn    (ising_rstn),
    .busy          (busy),
    .done          (done),
    .spins         (spins),
    .rd_count      (rd_count)
  );

  // Oscillator generator. Mode 1: osc0 toggles every 3 cycles, osc1 = ~osc0,
  // osc2 = osc0 one cycle late, osc3..5 = osc0. Mode 2: osc0 = 0, osc2 = 1,
  // osc3 density 1/2, osc4 density 3/5, osc5 density 2/5 (periods divide 10).
  initial begin
    osc_in = '0;
    forever begin
      @(posedge clk);
      #2;
      t++;
      case (mode)
        1: begin
          logic o0;
          o0        = ((t / 3) % 2) == 1;
          osc_in    = '0;
          osc_in[0] = o0;
          osc_in[1] = ~o0;
          osc_in[2] = prev0;
          osc_in[3] = o0;
          osc_in[4] = o0;
          osc_in[5] = o0;
          prev0     = o0;
        end
        2: begin
          osc_in    = '0;
          osc_in[2] = 1'b1;
          osc_in[3] = (t % 2) == 1;
          osc_in[4] = ((t % 5) == 0) || ((t % 5) == 1) || ((t % 5) == 3);
          osc_in[5] = (t % 5) < 2;
        end
        default: osc_in = osc_const;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start(input int w);
    sample_cycles = CNT_W'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the cycle index (k+cyc) at which done is seen; cycle 1 follows the start edge.
  task automatic wait_done(input int restart_at, output int cyc, output bit rl_ok);
    cyc   = 1;
    rl_ok = 1'b1;
    while (!done && cyc < 400) begin
      if (!(ising_rstn && busy)) rl_ok = 1'b0;
      start = (cyc == restart_at);
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic check_rd(input int sel, input int exp);
    rd_sel = SEL_W'(sel);
    #1;
    check($sformatf("rd_count[%0d]", sel), 32'(rd_count), exp);
  endtask

  int cyc;
  bit rl_ok;
  bit saw_done;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_rst       = 1'b1;
    start         = 1'b0;
    sample_cycles = '0;
    settle_cycles = '0;
    rd_sel        = '0;
    ticks(3);
    check("rst_ising_rstn", 32'(ising_rstn), 0);
    check("rst_busy",       32'(busy),       0);
    check("rst_done",       32'(done),       0);
    check("rst_spins",      32'(spins),      0);
    check("rst_rd_count",   32'(rd_count),   0);
    axi_rst = 1'b0;
    tick();

    // Matched phases
    mode = 0; osc_const = '0;
    ticks(3);
    do_start(10);
    check("start_busy",  32'(busy),       1);
    check("start_ising", 32'(ising_rstn), 1);
    wait_done(0, cyc, rl_ok);
    check("match_latency", 32'(cyc), 11 + EXTRA);
    check("match_runline", 32'(rl_ok), 1);
    check("match_spins",   32'(spins), 0);
    check("done_busy",     32'(busy), 0);
    check("done_ising",    32'(ising_rstn), 0);
    for (int i = 0; i < N; i++) check_rd(i, 0);
    tick();
    check("idle_done_pulse", 32'(done), 0);
    check("idle_ising",      32'(ising_rstn), 0);

    // Full and partial mismatch
    mode = 1;
    ticks(4);
    do_start(12);
    wait_done(0, cyc, rl_ok);
    check("mis_latency", 32'(cyc), 13 + EXTRA);
    check("mis_spins",   32'(spins), 32'h02);
    check_rd(1, 12);
    check_rd(2, 4);
    check_rd(3, 0);
    check_rd(6, 0);
    check_rd(7, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_ignored", 32'(busy), 0);

    // Tie rule: 5/10 -> 0, 6/10 -> 1
    mode = 2;
    ticks(4);
    do_start(10);
    wait_done(0, cyc, rl_ok);
    check("tie_latency", 32'(cyc), 11 + EXTRA);
    check("tie_spins",   32'(spins), 32'h14);
    check_rd(2, 10);
    check_rd(3, 5);
    check_rd(4, 6);
    check_rd(5, 4);

    // Zero window, then back-to-back start right after the DONE cycle
    mode = 0; osc_const = 6'b000010;
    ticks(3);
    do_start(0);
    wait_done(0, cyc, rl_ok);
    check("zero_latency", 32'(cyc), 2 + EXTRA);
    check("zero_spins",   32'(spins), 32'h02);
    check_rd(1, 1);
    tick();
    do_start(0);
    check("restart_busy", 32'(busy), 1);
    wait_done(0, cyc, rl_ok);
    check("restart_latency", 32'(cyc), 2 + EXTRA);

    // Second start during MEASURE does not extend the run
    osc_const = '0;
    ticks(3);
    do_start(10);
    wait_done(4, cyc, rl_ok);
    check("dup_start_latency", 32'(cyc), 11 + EXTRA);
    check("dup_start_runline", 32'(rl_ok), 1);

    // Mid-measurement reset
    mode = 1;
    ticks(4);
    do_start(100);
    ticks(39);
    check_rd(1, 39 - EXTRA);
    axi_rst = 1'b1;
    tick();
    axi_rst = 1'b0;
    check("mrst_ising", 32'(ising_rstn), 0);
    check("mrst_busy",  32'(busy), 0);
    check("mrst_spins", 32'(spins), 0);
    check_rd(1, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("mrst_no_done", 32'(saw_done), 0);

`ifdef PHASE_SAMPLER_SETTLE_EN
    // Settle phase: 6 settle cycles, first counted sample at edge k+7
    mode = 0; osc_const = 6'b000010;
    settle_cycles = 16'd5;
    rd_sel = 3'd1;
    ticks(3);
    do_start(8);
    check("settle_ising", 32'(ising_rstn), 1);
    cyc = 1;
    while (!done && cyc < 400) begin
      if (cyc == 7) check("settle_cnt_c7", 32'(rd_count), 0);
      if (cyc == 8) check("settle_cnt_c8", 32'(rd_count), 1);
      tick();
      cyc++;
    end
    check("settle_latency", 32'(cyc), 15);
    settle_cycles = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
